// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU memory subsystem: default widths,
// controller state encoding and latency-counter sizing.
package vscpu_pkg;

    localparam int VS_AW   = 14;
    localparam int VS_DW   = 32;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = $clog2(LAT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RD  = 2'd1,
        ST_HOST_RD = 2'd2,
        ST_HOST_WR = 2'd3
    } mc_state_e;

endpackage

// File: rtl/vscpu_lat_cnt.sv
// Loadable down-counter that times the SRAM read latency; done is high
// whenever the count has reached zero.
module vscpu_lat_cnt
    import vscpu_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Load on read issue, otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/vscpu_mem_ctrl.sv
// Single-port SRAM controller for the VerySimpleCPU core with a host port for
// program load and debug access; the core always wins arbitration.
module vscpu_mem_ctrl
    import vscpu_pkg::*;
#(
    parameter int AW      = VS_AW,
    parameter int DW      = VS_DW,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_vld,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          ram_csb,
    output logic          ram_web,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RAM_LAT - 1);

    mc_state_e     state_r;
    mc_state_e     state_nxt_s;
    logic [DW-1:0] cpu_rdata_r;
    logic [DW-1:0] host_rdata_r;
    logic          host_ack_r;
    logic          cnt_load_s;
    logic          cnt_done_s;

    vscpu_lat_cnt #(
        .CW (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (LAT_LOAD),
        .done     (cnt_done_s)
    );

    // Arbitration, next-state selection and same-cycle SRAM drive
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cpu_vld     = 1'b0;
        ram_csb     = 1'b1;
        ram_web     = 1'b1;
        ram_addr    = {AW{1'b0}};
        ram_din     = {DW{1'b0}};
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_vld = 1'b1;
                    if (cpu_req) begin
                        ram_csb  = 1'b0;
                        ram_addr = cpu_addr;
                        if (cpu_we) begin
                            ram_web = 1'b0;
                            ram_din = cpu_wdata;
                        end else begin
                            state_nxt_s = ST_CPU_RD;
                            cnt_load_s  = 1'b1;
                        end
                    // the ack cycle is skipped so a host still holding req is not served twice
                    end else if (host_req && !host_ack_r) begin
                        ram_csb  = 1'b0;
                        ram_addr = host_addr;
                        if (host_we) begin
                            ram_web     = 1'b0;
                            ram_din     = host_wdata;
                            state_nxt_s = ST_HOST_WR;
                        end else begin
                            state_nxt_s = ST_HOST_RD;
                            cnt_load_s  = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CPU_RD: begin
                    if (cnt_done_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CPU_RD;
                    end
                end
                ST_HOST_RD: begin
                    if (cnt_done_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOST_RD;
                    end
                end
                ST_HOST_WR: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register, read-data capture and host acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cpu_rdata_r  <= {DW{1'b0}};
            host_rdata_r <= {DW{1'b0}};
            host_ack_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            host_ack_r <= 1'b0;
            if ((state_r == ST_CPU_RD) && cnt_done_s) begin
                cpu_rdata_r <= ram_dout;
            end
            if ((state_r == ST_HOST_RD) && cnt_done_s) begin
                host_rdata_r <= ram_dout;
                host_ack_r   <= 1'b1;
            end
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_HOST_WR)) begin
                host_ack_r <= 1'b1;
            end
        end
    end

    assign cpu_rdata  = cpu_rdata_r;
    assign host_rdata = host_rdata_r;
    assign host_ack   = host_ack_r;

endmodule
